// File: rtl/serial_frame_rx.sv
// Framed serial receiver: start bit, WIDTH data bits, optional even parity, stop bit.
// Define SERIAL_RX_PARITY_EN to expect an even-parity bit after the data bits.
module serial_frame_rx #(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int LSB_FIRST    = 1
) (
  input  logic             clk,
  input  logic             CR,
  input  logic             SI,
  output logic [WIDTH-1:0] Q,
  output logic             VALID,
  output logic             FERR,
  output logic             PERR,
  output logic             BUSY
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(WIDTH + 1);
  localparam logic [TW-1:0] HALF     = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] FULL     = TW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef SERIAL_RX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t           state;
  logic             s1, s, s_prev;
  logic [TW-1:0]    timer;
  logic [BW-1:0]    nbits;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shreg_next;
`ifdef SERIAL_RX_PARITY_EN
  logic             par_err;
`endif

  always_comb begin
    shreg_next = shreg;
    if (LSB_FIRST != 0) shreg_next = {s, shreg[WIDTH-1:1]};
    else                shreg_next = {shreg[WIDTH-2:0], s};
  end

  assign BUSY = (state != IDLE);

  always_ff @(posedge clk) begin
    if (CR) begin
      state  <= IDLE;
      s1     <= 1'b1;
      s      <= 1'b1;
      s_prev <= 1'b1;
      timer  <= '0;
      nbits  <= '0;
      shreg  <= '0;
      Q      <= '0;
      VALID  <= 1'b0;
      FERR   <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
      PERR    <= 1'b0;
      par_err <= 1'b0;
`endif
    end else begin
      s1     <= SI;
      s      <= s1;
      s_prev <= s;
      VALID  <= 1'b0;
      FERR   <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
      PERR   <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (s_prev && !s) begin
            state <= START;
            timer <= '0;
          end
        end
        START: begin
          if (timer == HALF) begin
            timer <= '0;
            nbits <= '0;
`ifdef SERIAL_RX_PARITY_EN
            par_err <= 1'b0;
`endif
            state <= s ? IDLE : DATA;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        DATA: begin
          if (timer == FULL) begin
            timer <= '0;
            shreg <= shreg_next;
            nbits <= nbits + 1'b1;
            if (nbits == LAST_BIT) begin
`ifdef SERIAL_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end
`ifdef SERIAL_RX_PARITY_EN
        PARITY: begin
          if (timer == FULL) begin
            timer   <= '0;
            par_err <= (s != ^shreg);
            state   <= STOP;
          end else begin
            timer <= timer + 1'b1;
          end
        end
`endif
        STOP: begin
          if (timer == FULL) begin
            timer <= '0;
            state <= IDLE;
            // A low stop bit outranks a parity mismatch; only a clean frame updates Q.
            if (!s) begin
              FERR <= 1'b1;
`ifdef SERIAL_RX_PARITY_EN
            end else if (par_err) begin
              PERR <= 1'b1;
`endif
            end else begin
              Q     <= shreg;
              VALID <= 1'b1;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifndef SERIAL_RX_PARITY_EN
  assign PERR = 1'b0;
`endif

endmodule

// File: tb/tb_serial_frame_rx.sv
// Bench for serial_frame_rx: two receivers (LSB-first and MSB-first) share one line;
// a frame-level model predicts each strobe, its cycle and the visible Q.
module tb_serial_frame_rx;

  localparam int W   = 8;
  localparam int CPB = 4;
`ifdef SERIAL_RX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  typedef struct packed {
    logic        dut;
    logic [2:0]  kind;   // {VALID, FERR, PERR}
    logic [W-1:0] q;
    logic [31:0] cyc;
  } ev_t;

  logic clk = 1'b0;
  logic CR  = 1'b1;
  logic SI  = 1'b1;
  logic [W-1:0] q_lsb, q_msb;
  logic valid_lsb, ferr_lsb, perr_lsb, busy_lsb;
  logic valid_msb, ferr_msb, perr_msb, busy_msb;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int busy_cnt = 0;
  ev_t ev_q[$];
  ev_t exp_q[$];
  logic [W-1:0] exp_lsb, exp_msb;

  serial_frame_rx #(.WIDTH(W), .CLKS_PER_BIT(CPB), .LSB_FIRST(1)) u_lsb (
    .clk(clk), .CR(CR), .SI(SI), .Q(q_lsb),
    .VALID(valid_lsb), .FERR(ferr_lsb), .PERR(perr_lsb), .BUSY(busy_lsb)
  );

  serial_frame_rx #(.WIDTH(W), .CLKS_PER_BIT(CPB), .LSB_FIRST(0)) u_msb (
    .clk(clk), .CR(CR), .SI(SI), .Q(q_msb),
    .VALID(valid_msb), .FERR(ferr_msb), .PERR(perr_msb), .BUSY(busy_msb)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (valid_lsb || ferr_lsb || perr_lsb)
      ev_q.push_back('{dut: 1'b0, kind: {valid_lsb, ferr_lsb, perr_lsb}, q: q_lsb, cyc: cyc});
    if (valid_msb || ferr_msb || perr_msb)
      ev_q.push_back('{dut: 1'b1, kind: {valid_msb, ferr_msb, perr_msb}, q: q_msb, cyc: cyc});
    if (busy_lsb) busy_cnt++;
  end

  function automatic logic [W-1:0] reverse(input logic [W-1:0] d);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) r[i] = d[W-1-i];
    return r;
  endfunction

  // Frame-level prediction: the outcome appears a fixed number of cycles after the line falls.
  task automatic model_frame(input logic [W-1:0] data, input logic stop_val,
                             input logic par_bad, input int c0);
    int t;
    logic [2:0] kind;
    t = c0 + 3 + CPB / 2 + (W + 1 + PAR) * CPB;
    if (!stop_val) kind = 3'b010;
    else if (PAR != 0 && par_bad) kind = 3'b001;
    else begin
      kind = 3'b100;
      exp_lsb = data;
      exp_msb = reverse(data);
    end
    exp_q.push_back('{dut: 1'b0, kind: kind, q: exp_lsb, cyc: t});
    exp_q.push_back('{dut: 1'b1, kind: kind, q: exp_msb, cyc: t});
  endtask

  // Line order is always LSB first, as the transmitter shifts it out.
  task automatic send_frame(input logic [W-1:0] data, input logic stop_val,
                            input logic par_bad, input int tail_low);
    model_frame(data, stop_val, par_bad, cyc);
    SI = 1'b0;
    repeat (CPB) @(posedge clk);
    #1;
    for (int i = 0; i < W; i++) begin
      SI = data[i];
      repeat (CPB) @(posedge clk);
      #1;
    end
`ifdef SERIAL_RX_PARITY_EN
    SI = (^data) ^ par_bad;
    repeat (CPB) @(posedge clk);
    #1;
`endif
    SI = stop_val;
    repeat (CPB) @(posedge clk);
    #1;
    if (tail_low > 0) begin
      SI = 1'b0;
      repeat (tail_low) @(posedge clk);
      #1;
    end
  endtask

  task automatic idle(input int n);
    SI = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    CR = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
      SI = ~SI;
    end
    checks++;
    if ({q_lsb, q_msb} !== '0) begin
      errors++;
      $display("FAIL reset_q: got %h/%h, expected 00/00", q_lsb, q_msb);
    end
    checks++;
    if ({valid_lsb, ferr_lsb, perr_lsb, busy_lsb, valid_msb, ferr_msb, perr_msb, busy_msb} !== 8'h00) begin
      errors++;
      $display("FAIL reset_strobes: got %b%b%b%b %b%b%b%b, expected all 0",
               valid_lsb, ferr_lsb, perr_lsb, busy_lsb, valid_msb, ferr_msb, perr_msb, busy_msb);
    end
    CR = 1'b0;
    exp_lsb = '0;
    exp_msb = '0;
    idle(4);
  endtask

  task automatic test_known_frames;
    send_frame(8'hA5, 1'b1, 1'b0, 0);
    idle(4);
    send_frame(8'h01, 1'b1, 1'b0, 0);
    idle(4);
    checks++;
    if (ev_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL known_count: got %0d events, expected %0d", ev_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < ev_q.size(); i++) begin
      checks++;
      if (ev_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL known_ev%0d: got dut%0d kind=%b q=%h cyc=%0d, expected dut%0d kind=%b q=%h cyc=%0d", i,
                 ev_q[i].dut, ev_q[i].kind, ev_q[i].q, ev_q[i].cyc,
                 exp_q[i].dut, exp_q[i].kind, exp_q[i].q, exp_q[i].cyc);
      end
    end
    ev_q.delete();
    exp_q.delete();
  endtask

  task automatic test_glitch;
    busy_cnt = 0;
    SI = 1'b0;
    @(posedge clk);
    #1;
    idle(12);
    checks++;
    if (busy_cnt != CPB / 2) begin
      errors++;
      $display("FAIL glitch_busy: got %0d busy cycles, expected %0d", busy_cnt, CPB / 2);
    end
    checks++;
    if (ev_q.size() != 0) begin
      errors++;
      $display("FAIL glitch_strobe: got %0d events, expected 0", ev_q.size());
    end
    checks++;
    if (q_lsb !== exp_lsb || q_msb !== exp_msb) begin
      errors++;
      $display("FAIL glitch_q: got %h/%h, expected %h/%h", q_lsb, q_msb, exp_lsb, exp_msb);
    end
    ev_q.delete();
  endtask

  task automatic test_framing_error;
    send_frame(8'h3C, 1'b0, 1'b0, 20);
    checks++;
    if (busy_lsb !== 1'b0 || busy_msb !== 1'b0) begin
      errors++;
      $display("FAIL ferr_held_low_busy: got %b/%b, expected 0/0", busy_lsb, busy_msb);
    end
    idle(6);
    send_frame(8'h5A, 1'b1, 1'b0, 0);
    idle(4);
    checks++;
    if (ev_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL ferr_count: got %0d events, expected %0d", ev_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < ev_q.size(); i++) begin
      checks++;
      if (ev_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL ferr_ev%0d: got dut%0d kind=%b q=%h cyc=%0d, expected dut%0d kind=%b q=%h cyc=%0d", i,
                 ev_q[i].dut, ev_q[i].kind, ev_q[i].q, ev_q[i].cyc,
                 exp_q[i].dut, exp_q[i].kind, exp_q[i].q, exp_q[i].cyc);
      end
    end
    ev_q.delete();
    exp_q.delete();
  endtask

  task automatic test_back_to_back;
    send_frame(8'h12, 1'b1, 1'b0, 0);
    send_frame(8'h34, 1'b1, 1'b0, 0);
    idle(4);
    checks++;
    if (ev_q.size() != 4) begin
      errors++;
      $display("FAIL b2b_count: got %0d events, expected 4", ev_q.size());
    end else begin
      checks++;
      if (ev_q[2].cyc - ev_q[0].cyc != (W + 2 + PAR) * CPB) begin
        errors++;
        $display("FAIL b2b_spacing: got %0d cycles, expected %0d",
                 ev_q[2].cyc - ev_q[0].cyc, (W + 2 + PAR) * CPB);
      end
    end
    for (int i = 0; i < exp_q.size() && i < ev_q.size(); i++) begin
      checks++;
      if (ev_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL b2b_ev%0d: got dut%0d kind=%b q=%h cyc=%0d, expected dut%0d kind=%b q=%h cyc=%0d", i,
                 ev_q[i].dut, ev_q[i].kind, ev_q[i].q, ev_q[i].cyc,
                 exp_q[i].dut, exp_q[i].kind, exp_q[i].q, exp_q[i].cyc);
      end
    end
    ev_q.delete();
    exp_q.delete();
  endtask

`ifdef SERIAL_RX_PARITY_EN
  task automatic test_parity;
    send_frame(8'h07, 1'b1, 1'b1, 0);
    idle(3);
    send_frame(8'h07, 1'b1, 1'b0, 0);
    idle(4);
    checks++;
    if (ev_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL parity_count: got %0d events, expected %0d", ev_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < ev_q.size(); i++) begin
      checks++;
      if (ev_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL parity_ev%0d: got dut%0d kind=%b q=%h cyc=%0d, expected dut%0d kind=%b q=%h cyc=%0d", i,
                 ev_q[i].dut, ev_q[i].kind, ev_q[i].q, ev_q[i].cyc,
                 exp_q[i].dut, exp_q[i].kind, exp_q[i].q, exp_q[i].cyc);
      end
    end
    ev_q.delete();
    exp_q.delete();
  endtask
`endif

  task automatic test_random;
    logic [W-1:0] data;
    logic stop_val, par_bad;
    for (int n = 0; n < 14; n++) begin
      data     = W'($urandom);
      stop_val = ($urandom_range(0, 7) != 0);
      par_bad  = ($urandom_range(0, 3) == 0);
      send_frame(data, stop_val, par_bad, 0);
      idle(stop_val ? $urandom_range(0, 3) : $urandom_range(2, 4));
    end
    idle(4);
    checks++;
    if (ev_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL random_count: got %0d events, expected %0d", ev_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < ev_q.size(); i++) begin
      checks++;
      if (ev_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL random_ev%0d: got dut%0d kind=%b q=%h cyc=%0d, expected dut%0d kind=%b q=%h cyc=%0d", i,
                 ev_q[i].dut, ev_q[i].kind, ev_q[i].q, ev_q[i].cyc,
                 exp_q[i].dut, exp_q[i].kind, exp_q[i].q, exp_q[i].cyc);
      end
    end
    checks++;
    if (q_lsb !== exp_lsb || q_msb !== exp_msb) begin
      errors++;
      $display("FAIL random_final_q: got %h/%h, expected %h/%h", q_lsb, q_msb, exp_lsb, exp_msb);
    end
    ev_q.delete();
    exp_q.delete();
  endtask

  task automatic test_cr_mid_frame;
    logic [W-1:0] data;
    data = 8'h6B;
    SI = 1'b0;
    repeat (CPB) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      SI = data[i];
      repeat (CPB) @(posedge clk);
      #1;
    end
    checks++;
    if (busy_lsb !== 1'b1) begin
      errors++;
      $display("FAIL cr_busy_before: got %b, expected 1", busy_lsb);
    end
    SI = 1'b1;
    CR = 1'b1;
    @(posedge clk);
    #1;
    CR = 1'b0;
    exp_lsb = '0;
    exp_msb = '0;
    checks++;
    if (busy_lsb !== 1'b0 || busy_msb !== 1'b0) begin
      errors++;
      $display("FAIL cr_busy_after: got %b/%b, expected 0/0", busy_lsb, busy_msb);
    end
    idle(3 * (W + 2 + PAR) * CPB);
    checks++;
    if (ev_q.size() != 0) begin
      errors++;
      $display("FAIL cr_strobe: got %0d events, expected 0", ev_q.size());
    end
    checks++;
    if (q_lsb !== exp_lsb || q_msb !== exp_msb) begin
      errors++;
      $display("FAIL cr_q: got %h/%h, expected %h/%h", q_lsb, q_msb, exp_lsb, exp_msb);
    end
    ev_q.delete();
  endtask

  initial begin
    test_reset();
    test_known_frames();
    test_glitch();
    test_framing_error();
    test_back_to_back();
`ifdef SERIAL_RX_PARITY_EN
    test_parity();
`endif
    test_random();
    test_cr_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
